traffic_phase_controller: RTL and testbench
===========================================

// Module: traffic_phase_controller
// PURPOSE
// Parametrised, actuated 4-approach traffic controller driving main road 1 (M1), main road 2 (M2),
// main turn lane (MT) and side road (S). Phase durations are set by parameters and counted in
// time-base ticks. Turn and side phases are served only on request. Adds all-red clearance and
// maintenance flash. Sits between the tick generator/sensor inputs and the lamp drivers.
// PARAMETERS
// CNT_W   8  timer width; every T_* must be >=1 and <= 2**CNT_W
// T_MAIN  7  minimum main green, ticks
// T_TURN  5  turn green, ticks
// T_SIDE  3  side green, ticks
// T_YEL   2  every yellow phase, ticks
// T_RED   1  all-red clearance, ticks
// T_WALK  2  pedestrian walk window, ticks (PED_WALK_EN only)
// PORTS
// clk       in   1  system clock
// rst       in   1  asynchronous, active-high reset
// tick      in   1  one-cycle time-base strobe
// turn_req  in   1  turn-lane vehicle sensor (level or pulse)
// side_req  in   1  side-road vehicle sensor (level or pulse)
// flash     in   1  maintenance flash request (level)
// light_M1  out  3  lamp {R,Y,G}, one-hot
// light_M2  out  3  lamp {R,Y,G}, one-hot
// light_MT  out  3  lamp {R,Y,G}, one-hot
// light_S   out  3  lamp {R,Y,G}, one-hot
// phase     out  4  current state code
// BEHAVIOUR
// - One clock; reset is asynchronous and active-high. Reset gives state CLR_B, timer 0, latches 0,
//   all lights 3'b100, phase 8.
// - Lights and phase are a pure decode of registered state and the flash toggle. No input-to-output path.
// - States, with code, lights (M1/M2/MT/S) and exit:
//   0 MAIN_G G/G/R/R: timer saturates at T_MAIN-1; then exit on tick. turn pending goes to M2_Y,
//     else side pending goes to MAIN_Y, else the controller rests in MAIN_G.
//   1 M2_Y   G/Y/R/R: T_YEL, then TURN_G.
//   2 TURN_G G/R/G/R: T_TURN, then TURN_Y.
//   3 TURN_Y Y/R/Y/R: T_YEL, then CLR_A.
//   4 MAIN_Y Y/Y/R/R: T_YEL, then CLR_A.
//   5 CLR_A  all R:   T_RED. side pending goes to SIDE_G, else MAIN_G.
//   6 SIDE_G R/R/R/G: T_SIDE, then SIDE_Y.
//   7 SIDE_Y R/R/R/Y: T_YEL, then CLR_B.
//   8 CLR_B  all R:   T_RED, then MAIN_G.
//   9 FLASH:          M1/M2/MT alternate Y and off (3'b000); S alternates R and off. Toggle on each tick.
// - Timed exit happens on the clk edge where tick=1 and timer==T-1. The timer clears on every state entry.
//   With tick=0 the timer and state hold.
// - Request latches turn_p and side_p set on any cycle the sensor is high, tick or not.
//   turn_p clears on entry to TURN_G; side_p clears on entry to SIDE_G. Clear beats a simultaneous set.
// - flash=1 enters FLASH on the next clk edge from any state, ignoring tick, with lamps on (Y/Y/Y/R).
//   flash=0 in FLASH goes to CLR_B on the next edge. Latches are held throughout FLASH.
// - rst mid-phase forces all-red immediately, with no clk edge needed.
// CONFIGURATION
// - PED_WALK_EN defined: adds ped_req in 1 (latched like side_req, sets side_p and ped_p) and
//   ped_walk out 1. ped_walk=1 during the first T_WALK ticks of SIDE_G when ped_p was set at entry,
//   else 0. ped_p clears on SIDE_G entry; reset value 0.
// - PED_WALK_EN undefined: ports, ped_p and walk timer are absent. Behaviour otherwise identical.
// TESTING (defaults, tick=1 every cycle)
// 1 Release rst, no requests: CLR_B 1 cycle, then MAIN_G forever. M1=M2=001, MT=S=100, phase 0.
// 2 side_req pulse on cycle 3 of MAIN_G: MAIN_G lasts 7, MAIN_Y 2, CLR_A 1, SIDE_G 3 (S=001),
//   SIDE_Y 2, CLR_B 1, then MAIN_G with side_p=0.
// 3 turn_req and side_req together: M2_Y 2, TURN_G 5 (MT=001), TURN_Y 2, CLR_A 1, SIDE_G 3,
//   SIDE_Y 2, CLR_B 1, MAIN_G.
// 4 tick every 4th cycle: every phase length scales by 4; state is frozen between ticks.
// 5 flash raised in SIDE_G: next edge gives phase 9 and Y/Y/Y/R, toggling each tick.
//   flash dropped: CLR_B 1, then MAIN_G. A pending turn_p is still served afterwards.
// 6 rst pulse mid TURN_G between edges: all lights 100 and phase 8 at once, then scenario 1 sequence.
// 7 PED_WALK_EN, ped_req pulse: SIDE_G served; ped_walk=1 for 2 cycles, then 0 for the last cycle.

Source files
------------

// File: rtl/traffic_phase_controller.sv
// Actuated four-approach traffic controller with all-red clearance and maintenance flash.
// Optional pedestrian walk window is enabled by defining PED_WALK_EN.
module traffic_phase_controller #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned T_MAIN = 7,
    parameter int unsigned T_TURN = 5,
    parameter int unsigned T_SIDE = 3,
    parameter int unsigned T_YEL  = 2,
    parameter int unsigned T_RED  = 1
`ifdef PED_WALK_EN
    ,
    parameter int unsigned T_WALK = 2
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       turn_req,
    input  logic       side_req,
    input  logic       flash,
`ifdef PED_WALK_EN
    input  logic       ped_req,
    output logic       ped_walk,
`endif
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        MAIN_G = 4'd0,
        M2_Y   = 4'd1,
        TURN_G = 4'd2,
        TURN_Y = 4'd3,
        MAIN_Y = 4'd4,
        CLR_A  = 4'd5,
        SIDE_G = 4'd6,
        SIDE_Y = 4'd7,
        CLR_B  = 4'd8,
        FLASH  = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] MAIN_LAST = CNT_W'(T_MAIN - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(T_TURN - 1);
    localparam logic [CNT_W-1:0] SIDE_LAST = CNT_W'(T_SIDE - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(T_RED - 1);

    localparam logic [2:0] L_R   = 3'b100;
    localparam logic [2:0] L_Y   = 3'b010;
    localparam logic [2:0] L_G   = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n, last;
    logic             turn_p, side_p, flash_on, flash_on_n;
    logic             turn_entry, side_entry, side_set;

    // Terminal timer value of the current phase
    always_comb begin
        last = '0;
        case (state)
            MAIN_G:                        last = MAIN_LAST;
            M2_Y, TURN_Y, MAIN_Y, SIDE_Y:  last = YEL_LAST;
            TURN_G:                        last = TURN_LAST;
            SIDE_G:                        last = SIDE_LAST;
            CLR_A, CLR_B:                  last = RED_LAST;
            default:                       last = '0;
        endcase
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        flash_on_n = flash_on;
        if (flash) begin
            if (state != FLASH) begin
                state_n    = FLASH;
                timer_n    = '0;
                flash_on_n = 1'b1;
            end else if (tick) begin
                flash_on_n = ~flash_on;
            end
        end else if (state == FLASH) begin
            state_n = CLR_B;
            timer_n = '0;
        end else if (tick) begin
            if (timer != last) begin
                timer_n = timer + CNT_W'(1);
            end else begin
                timer_n = '0;
                case (state)
                    MAIN_G: begin
                        // Rest in main green with the timer saturated until a request arrives
                        if (turn_p)      state_n = M2_Y;
                        else if (side_p) state_n = MAIN_Y;
                        else             timer_n = timer;
                    end
                    M2_Y:    state_n = TURN_G;
                    TURN_G:  state_n = TURN_Y;
                    TURN_Y:  state_n = CLR_A;
                    MAIN_Y:  state_n = CLR_A;
                    CLR_A:   state_n = side_p ? SIDE_G : MAIN_G;
                    SIDE_G:  state_n = SIDE_Y;
                    SIDE_Y:  state_n = CLR_B;
                    CLR_B:   state_n = MAIN_G;
                    default: state_n = CLR_B;
                endcase
            end
        end
    end

    assign turn_entry = (state_n == TURN_G) && (state != TURN_G);
    assign side_entry = (state_n == SIDE_G) && (state != SIDE_G);
`ifdef PED_WALK_EN
    assign side_set   = side_req | ped_req;
`else
    assign side_set   = side_req;
`endif

`ifdef PED_WALK_EN
    logic ped_p, walk_on;
`endif

    // Request latches are frozen during FLASH; a phase entry clear wins over a set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLR_B;
            timer    <= '0;
            flash_on <= 1'b0;
            turn_p   <= 1'b0;
            side_p   <= 1'b0;
`ifdef PED_WALK_EN
            ped_p    <= 1'b0;
            walk_on  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            flash_on <= flash_on_n;
            if (turn_entry)                        turn_p <= 1'b0;
            else if (state != FLASH && turn_req)   turn_p <= 1'b1;
            if (side_entry)                        side_p <= 1'b0;
            else if (state != FLASH && side_set)   side_p <= 1'b1;
`ifdef PED_WALK_EN
            if (side_entry) begin
                ped_p   <= 1'b0;
                walk_on <= ped_p;
            end else if (state != FLASH && ped_req) begin
                ped_p   <= 1'b1;
            end
`endif
        end
    end

`ifdef PED_WALK_EN
    assign ped_walk = (state == SIDE_G) && walk_on &&
                      ({1'b0, timer} < (CNT_W + 1)'(T_WALK));
`endif

    // Lamp decode from registered state only
    always_comb begin
        light_M1 = L_R;
        light_M2 = L_R;
        light_MT = L_R;
        light_S  = L_R;
        phase    = 4'(state);
        case (state)
            MAIN_G: begin light_M1 = L_G; light_M2 = L_G; end
            M2_Y:   begin light_M1 = L_G; light_M2 = L_Y; end
            TURN_G: begin light_M1 = L_G; light_MT = L_G; end
            TURN_Y: begin light_M1 = L_Y; light_MT = L_Y; end
            MAIN_Y: begin light_M1 = L_Y; light_M2 = L_Y; end
            SIDE_G: light_S = L_G;
            SIDE_Y: light_S = L_Y;
            FLASH: begin
                light_M1 = flash_on ? L_Y : L_OFF;
                light_M2 = flash_on ? L_Y : L_OFF;
                light_MT = flash_on ? L_Y : L_OFF;
                light_S  = flash_on ? L_R : L_OFF;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller: a phase/remaining-ticks reference model
// predicts every clock edge and every reset assertion; a monitor pops and compares.
module tb_traffic_phase_controller;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned T_MAIN = 7;
    localparam int unsigned T_TURN = 5;
    localparam int unsigned T_SIDE = 3;
    localparam int unsigned T_YEL  = 2;
    localparam int unsigned T_RED  = 1;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] O = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, turn_req = 1'b0, side_req = 1'b0, flash = 1'b0;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic [3:0] phase;
`ifdef PED_WALK_EN
    logic       ped_req = 1'b0;
    logic       ped_walk;
`endif

    traffic_phase_controller #(
        .CNT_W(CNT_W), .T_MAIN(T_MAIN), .T_TURN(T_TURN), .T_SIDE(T_SIDE),
        .T_YEL(T_YEL), .T_RED(T_RED)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .turn_req(turn_req),
        .side_req(side_req), .flash(flash),
`ifdef PED_WALK_EN
        .ped_req(ped_req), .ped_walk(ped_walk),
`endif
        .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT),
        .light_S(light_S), .phase(phase)
    );

    always #5 clk = ~clk;

    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit go       = 1'b0;

    // Reference model: current phase, ticks still to serve, request flags, flash lamp state
    int m_ph, m_left;
    bit m_turn, m_side, m_fon;

    function automatic int dur(input int p);
        case (p)
            0:          return T_MAIN;
            1, 3, 4, 7: return T_YEL;
            2:          return T_TURN;
            6:          return T_SIDE;
            default:    return T_RED;
        endcase
    endfunction

    function automatic logic [15:0] expect_vec();
        logic [11:0] l;
        case (m_ph)
            0: l = {G, G, R, R};
            1: l = {G, Y, R, R};
            2: l = {G, R, G, R};
            3: l = {Y, R, Y, R};
            4: l = {Y, Y, R, R};
            6: l = {R, R, R, G};
            7: l = {R, R, R, Y};
            9: l = m_fon ? {Y, Y, Y, R} : {O, O, O, O};
            default: l = {R, R, R, R};
        endcase
        return {4'(m_ph), l};
    endfunction

    task automatic model_reset();
        m_ph = 8; m_left = T_RED; m_turn = 1'b0; m_side = 1'b0; m_fon = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit tr, input bit sr, input bit fl);
        int nxt;
        nxt = m_ph;
        if (fl) begin
            if (m_ph != 9) begin nxt = 9; m_fon = 1'b1; end
            else if (t) m_fon = !m_fon;
        end else if (m_ph == 9) begin
            nxt = 8;
        end else if (t) begin
            if (m_left > 1) m_left--;
            else begin
                case (m_ph)
                    0: nxt = m_turn ? 1 : (m_side ? 4 : 0);
                    1: nxt = 2;
                    2: nxt = 3;
                    3: nxt = 5;
                    4: nxt = 5;
                    5: nxt = m_side ? 6 : 0;
                    6: nxt = 7;
                    7: nxt = 8;
                    default: nxt = 0;
                endcase
            end
        end
        if (m_ph != 9) begin
            m_turn = m_turn | tr;
            m_side = m_side | sr;
        end
        if (nxt != m_ph) begin
            m_left = dur(nxt);
            if (nxt == 2) m_turn = 1'b0;
            if (nxt == 6) m_side = 1'b0;
        end
        m_ph = nxt;
    endtask

    // Monitor: the DUT presents a new output after each clock edge and each reset assertion
    initial begin
        logic [15:0] e, got;
        wait (go);
        forever begin
            @(posedge clk or posedge rst);
            #1;
            got = {phase, light_M1, light_M2, light_MT, light_S};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow t=%0t got=%h", $time, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL lamps_phase t=%0t got phase=%0d lamps=%o exp phase=%0d lamps=%o",
                             $time, got[15:12], got[11:0], e[15:12], e[11:0]);
                end
            end
        end
    end

    initial begin
        int flash_left, cool;
        bit t, tr, sr, fl, do_rst;
        flash_left = 0;
        cool = 0;
        model_reset();
        repeat (2) @(negedge clk);
        exp_q.push_back(expect_vec());
        go = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            t = 1'b1; tr = 1'b0; sr = 1'b0; fl = 1'b0; do_rst = 1'b0;
            if (k < 150) begin
                // Directed prologue: side alone, turn+side together, flash, reset, slow tick
                sr = (k == 10) || (k == 40);
                tr = (k == 40) || (k == 70);
                fl = (k >= 75) && (k <= 82);
                do_rst = (k == 90) || (k == 130);
                if (k >= 100) t = (k % 4 == 0);
                if (k == 104 || k == 110) sr = 1'b1;
                if (k == 112) tr = 1'b1;
            end else begin
                case ((k / 200) % 3)
                    0:       t = 1'b1;
                    1:       t = (k % 4 == 0);
                    default: t = 1'($urandom_range(0, 1));
                endcase
                if (flash_left == 0 && ($urandom % 250) == 0)
                    flash_left = $urandom_range(3, 12);
                fl = (flash_left > 0);
                if (flash_left > 0) begin
                    flash_left--;
                    cool = 2;
                end else if (cool > 0) begin
                    cool--;
                end
                if (cool == 0) begin
                    tr = (($urandom % 20) == 0);
                    sr = (($urandom % 20) == 0);
                    do_rst = (($urandom % 400) == 0);
                end
            end
            if (do_rst) begin
                tick = 1'b0; turn_req = 1'b0; side_req = 1'b0; flash = 1'b0;
                #2;
                model_reset();
                exp_q.push_back(expect_vec());
                rst = 1'b1;
                exp_q.push_back(expect_vec());
            end else begin
                tick = t; turn_req = tr; side_req = sr; flash = fl;
                model_step(t, tr, sr, fl);
                exp_q.push_back(expect_vec());
            end
        end
        @(posedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
